// File: rtl/packet_replicator_pkg.sv
// -----------------------------------------------------------------------------
// packet_replicator_pkg
// Shared definitions for the packet replicator: FSM state encoding, the
// standard TUSER dst-port field location, the standard port codes and a
// helper that derives the per-output FIFO programmable-full threshold.
// No ports (package).
// -----------------------------------------------------------------------------
package packet_replicator_pkg;

  typedef enum logic {
    ST_SOP    = 1'b0,
    ST_IN_PKT = 1'b1
  } state_t;

  // TUSER dst-port field location used across the capture datapath.
  localparam int DST_PORT_LSB_DEF   = 24;
  localparam int DST_PORT_WIDTH_DEF = 8;

  // Standard port codes: host port and first MAC port.
  localparam logic [7:0] PORT_HOST = 8'h80;
  localparam logic [7:0] PORT_MAC0 = 8'h01;

  // A FIFO at or above this fill level cannot guarantee room for a
  // maximum-size packet, so it is treated as having no room at SOP.
  function automatic int prog_full_thresh(input int depth_bits, input int max_words);
    return (1 << depth_bits) - max_words;
  endfunction

endpackage

// File: rtl/packet_replicator_if.sv
// -----------------------------------------------------------------------------
// packet_replicator_if
// Bundles the replicator's streaming signals: one AXI4-Stream input, the
// packed NUM_OUTPUTS AXI4-Stream outputs, the per-output enable mask and the
// per-output drop pulse.
// Modports:
//   slave  - replicator view (consumes s_axis_*, produces m_axis_*)
//   master - environment view (produces s_axis_*, consumes m_axis_*)
// -----------------------------------------------------------------------------
interface packet_replicator_if #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_OUTPUTS        = 2
);
  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;

  logic [C_AXIS_DATA_WIDTH-1:0]              s_axis_tdata;
  logic [STRB_W-1:0]                         s_axis_tstrb;
  logic [C_AXIS_TUSER_WIDTH-1:0]             s_axis_tuser;
  logic                                      s_axis_tvalid;
  logic                                      s_axis_tready;
  logic                                      s_axis_tlast;

  logic [NUM_OUTPUTS*C_AXIS_DATA_WIDTH-1:0]  m_axis_tdata;
  logic [NUM_OUTPUTS*STRB_W-1:0]             m_axis_tstrb;
  logic [NUM_OUTPUTS*C_AXIS_TUSER_WIDTH-1:0] m_axis_tuser;
  logic [NUM_OUTPUTS-1:0]                    m_axis_tvalid;
  logic [NUM_OUTPUTS-1:0]                    m_axis_tready;
  logic [NUM_OUTPUTS-1:0]                    m_axis_tlast;

  logic [NUM_OUTPUTS-1:0]                    out_enable;
  logic [NUM_OUTPUTS-1:0]                    drop_pulse;

  modport slave (
    input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    output s_axis_tready,
    output m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    input  m_axis_tready,
    input  out_enable,
    output drop_pulse
  );

  modport master (
    output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
    input  s_axis_tready,
    input  m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tvalid, m_axis_tlast,
    output m_axis_tready,
    output out_enable,
    input  drop_pulse
  );

endinterface

// File: rtl/packet_replicator_fifo.sv
// -----------------------------------------------------------------------------
// packet_replicator_fifo
// Per-output fallthrough FIFO: the head entry is presented on dout whenever
// the FIFO is not empty, so a write at cycle N is readable at cycle N+1.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (pointers/count only)
//   din, wr_en      write side (writes while full are ignored)
//   rd_en           pop the head entry (ignored while empty)
//   dout            head entry
//   full, empty     occupancy flags
//   prog_full       fill level >= PROG_FULL_THRESH
// -----------------------------------------------------------------------------
module packet_replicator_fifo #(
  parameter int WIDTH            = 8,
  parameter int DEPTH_BITS       = 7,
  parameter int PROG_FULL_THRESH = 78
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             prog_full
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  do_wr;
  logic                  do_rd;

  assign full      = (count == (DEPTH_BITS + 1)'(DEPTH));
  assign empty     = (count == '0);
  assign prog_full = (count >= (DEPTH_BITS + 1)'(PROG_FULL_THRESH));
  assign do_wr     = wr_en & ~full;
  assign do_rd     = rd_en & ~empty;
  assign dout      = mem[rd_ptr];

  // Storage carries data only and is not reset.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/packet_replicator.sv
// -----------------------------------------------------------------------------
// packet_replicator
// Replicates each AXI4-Stream packet from one input to NUM_OUTPUTS
// independently back-pressured outputs, rewriting the TUSER dst-port field of
// the first beat with a per-output port code. The output set is chosen at SOP
// from out_enable; with DROP_ON_FULL=1 an output lacking room for a
// maximum-size packet has its copy dropped (reported on drop_pulse), with
// DROP_ON_FULL=0 the input stalls at SOP until every wanted output has room.
// Ports:
//   axi_aclk     clock
//   axi_aresetn  asynchronous active-low reset
//   bus          packet_replicator_if.slave: s_axis_* input stream,
//                packed m_axis_* output streams, out_enable, drop_pulse
// -----------------------------------------------------------------------------
module packet_replicator
  import packet_replicator_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_OUTPUTS        = 2,
  parameter int FIFO_DEPTH_BITS    = 7,
  parameter int MAX_PKT_WORDS      = 50,
  parameter int DST_PORT_LSB       = DST_PORT_LSB_DEF,
  parameter int DST_PORT_WIDTH     = DST_PORT_WIDTH_DEF,
  parameter logic [NUM_OUTPUTS*DST_PORT_WIDTH-1:0] OUT_DST_PORTS = {PORT_HOST, PORT_MAC0},
  parameter int DROP_ON_FULL       = 1
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  packet_replicator_if.slave bus
);

  localparam int DW     = C_AXIS_DATA_WIDTH;
  localparam int TW     = C_AXIS_TUSER_WIDTH;
  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
  localparam int FW     = 1 + TW + STRB_W + DW;

  state_t                 state;
  logic [NUM_OUTPUTS-1:0] sel_mask;
  logic [NUM_OUTPUTS-1:0] drop_pulse_r;
  logic [NUM_OUTPUTS-1:0] want;
  logic [NUM_OUTPUTS-1:0] room;
  logic [NUM_OUTPUTS-1:0] full;
  logic [NUM_OUTPUTS-1:0] empty;
  logic [NUM_OUTPUTS-1:0] prog_full;
  logic [NUM_OUTPUTS-1:0] sop_mask;
  logic [NUM_OUTPUTS-1:0] mask;
  logic [NUM_OUTPUTS-1:0] wr_en;
  logic                   s_ready;
  logic                   accept;

  function automatic logic [TW-1:0] set_dst(input logic [TW-1:0] user,
                                            input logic [DST_PORT_WIDTH-1:0] port);
    logic [TW-1:0] r;
    r = user;
    r[DST_PORT_LSB +: DST_PORT_WIDTH] = port;
    return r;
  endfunction

  assign want              = bus.out_enable;
  assign room              = ~prog_full;
  assign accept            = bus.s_axis_tvalid & s_ready;
  assign bus.s_axis_tready = s_ready;
  assign bus.drop_pulse    = drop_pulse_r;

  // The output set is decided combinationally on the SOP beat so the first
  // beat can be written without a bubble; later beats use the latched set.
  // In IN_PKT only a full selected FIFO stalls, so oversize packets are
  // never truncated.
  always_comb begin
    sop_mask = (DROP_ON_FULL != 0) ? (want & room) : want;
    if (state == ST_SOP) begin
      mask    = sop_mask;
      s_ready = (DROP_ON_FULL != 0) ? 1'b1 : &(room | ~want);
    end else begin
      mask    = sel_mask;
      s_ready = &(~full | ~sel_mask);
    end
  end

  assign wr_en = {NUM_OUTPUTS{accept}} & mask;

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state        <= ST_SOP;
      sel_mask     <= '0;
      drop_pulse_r <= '0;
    end else begin
      drop_pulse_r <= '0;
      case (state)
        ST_SOP: begin
          if (accept) begin
            sel_mask     <= sop_mask;
            drop_pulse_r <= (DROP_ON_FULL != 0) ? (want & ~room) : '0;
            if (!bus.s_axis_tlast) state <= ST_IN_PKT;
          end
        end
        default: begin
          if (accept && bus.s_axis_tlast) state <= ST_SOP;
        end
      endcase
    end
  end

  for (genvar i = 0; i < NUM_OUTPUTS; i++) begin : g_out
    logic [TW-1:0] user_i;
    logic [FW-1:0] din_i;
    logic [FW-1:0] dout_i;

    // Only the first beat of a packet carries metadata to rewrite.
    assign user_i = (state == ST_SOP)
                  ? set_dst(bus.s_axis_tuser, OUT_DST_PORTS[i*DST_PORT_WIDTH +: DST_PORT_WIDTH])
                  : bus.s_axis_tuser;
    assign din_i  = {bus.s_axis_tlast, user_i, bus.s_axis_tstrb, bus.s_axis_tdata};

    packet_replicator_fifo #(
      .WIDTH            (FW),
      .DEPTH_BITS       (FIFO_DEPTH_BITS),
      .PROG_FULL_THRESH (prog_full_thresh(FIFO_DEPTH_BITS, MAX_PKT_WORDS))
    ) u_fifo (
      .clk       (axi_aclk),
      .rst_n     (axi_aresetn),
      .din       (din_i),
      .wr_en     (wr_en[i]),
      .rd_en     (bus.m_axis_tready[i]),
      .dout      (dout_i),
      .full      (full[i]),
      .empty     (empty[i]),
      .prog_full (prog_full[i])
    );

    assign bus.m_axis_tdata[i*DW +: DW]         = dout_i[DW-1:0];
    assign bus.m_axis_tstrb[i*STRB_W +: STRB_W] = dout_i[DW +: STRB_W];
    assign bus.m_axis_tuser[i*TW +: TW]         = dout_i[DW+STRB_W +: TW];
    assign bus.m_axis_tlast[i]                  = dout_i[FW-1];
    assign bus.m_axis_tvalid[i]                 = ~empty[i];
  end

endmodule

// File: tb/tb_packet_replicator.sv
// -----------------------------------------------------------------------------
// tb_packet_replicator
// Directed bench for packet_replicator. Two instances share clock and reset:
// dut_d (DROP_ON_FULL=1) and dut_s (DROP_ON_FULL=0). Small FIFOs (16 beats,
// 6-beat max packet, prog_full at 10) keep the fill scenarios short.
// out0 carries dst 8'h80, out1 carries dst 8'h01.
// -----------------------------------------------------------------------------
module tb_packet_replicator;

  localparam int DW  = 32;
  localparam int TU  = 64;
  localparam int NO  = 2;
  localparam int SW  = DW / 8;
  localparam int EW  = 1 + TU + SW + DW;
  localparam logic [15:0] PORTS = 16'h0180;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  packet_replicator_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TU), .NUM_OUTPUTS(NO)) bd ();
  packet_replicator_if #(.C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TU), .NUM_OUTPUTS(NO)) bs ();

  packet_replicator #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TU), .NUM_OUTPUTS(NO),
    .FIFO_DEPTH_BITS(4), .MAX_PKT_WORDS(6), .DST_PORT_LSB(24), .DST_PORT_WIDTH(8),
    .OUT_DST_PORTS(PORTS), .DROP_ON_FULL(1)
  ) dut_d (.axi_aclk(clk), .axi_aresetn(rst_n), .bus(bd));

  packet_replicator #(
    .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(TU), .NUM_OUTPUTS(NO),
    .FIFO_DEPTH_BITS(4), .MAX_PKT_WORDS(6), .DST_PORT_LSB(24), .DST_PORT_WIDTH(8),
    .OUT_DST_PORTS(PORTS), .DROP_ON_FULL(0)
  ) dut_s (.axi_aclk(clk), .axi_aresetn(rst_n), .bus(bs));

  // Output capture: entries are {tlast, tuser, tstrb, tdata}.
  logic [EW-1:0] q0d[$];
  logic [EW-1:0] q1d[$];
  logic [EW-1:0] q0s[$];
  logic [EW-1:0] q1s[$];
  logic [NO-1:0] drop_seen_d = '0;
  logic [NO-1:0] drop_seen_s = '0;

  always @(negedge clk) begin
    if (bd.m_axis_tvalid[0] && bd.m_axis_tready[0])
      q0d.push_back({bd.m_axis_tlast[0], bd.m_axis_tuser[0 +: TU], bd.m_axis_tstrb[0 +: SW], bd.m_axis_tdata[0 +: DW]});
    if (bd.m_axis_tvalid[1] && bd.m_axis_tready[1])
      q1d.push_back({bd.m_axis_tlast[1], bd.m_axis_tuser[TU +: TU], bd.m_axis_tstrb[SW +: SW], bd.m_axis_tdata[DW +: DW]});
    if (bs.m_axis_tvalid[0] && bs.m_axis_tready[0])
      q0s.push_back({bs.m_axis_tlast[0], bs.m_axis_tuser[0 +: TU], bs.m_axis_tstrb[0 +: SW], bs.m_axis_tdata[0 +: DW]});
    if (bs.m_axis_tvalid[1] && bs.m_axis_tready[1])
      q1s.push_back({bs.m_axis_tlast[1], bs.m_axis_tuser[TU +: TU], bs.m_axis_tstrb[SW +: SW], bs.m_axis_tdata[DW +: DW]});
    drop_seen_d = drop_seen_d | bd.drop_pulse;
    drop_seen_s = drop_seen_s | bs.drop_pulse;
  end

  // Beat k of packet p.
  function automatic logic [DW-1:0] bdata(input int p, input int k);
    return 32'hA000_0000 | DW'(p << 8) | DW'(k);
  endfunction

  function automatic logic [SW-1:0] bstrb(input logic last);
    return last ? 4'h7 : 4'hF;
  endfunction

  // Every input beat carries 8'h5A in the dst field so a missing or stray
  // rewrite is visible.
  function automatic logic [TU-1:0] buser(input int p, input int k);
    if (k == 0) return {32'hFEED_0000 | 32'(p), 8'h5A, 24'(p)};
    return {32'hCAFE_0000 | 32'(k), 8'h5A, 24'(k)};
  endfunction

  function automatic logic [EW-1:0] exp_entry(input int p, input int k, input int n, input int o);
    logic [TU-1:0] u;
    logic          l;
    u = buser(p, k);
    if (k == 0) u[31:24] = (o == 0) ? 8'h80 : 8'h01;
    l = (k == n - 1);
    return {l, u, bstrb(l), bdata(p, k)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_d(input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input logic [TU-1:0] u, input logic l, output int w);
    w = 0;
    bd.s_axis_tdata  = d;
    bd.s_axis_tstrb  = s;
    bd.s_axis_tuser  = u;
    bd.s_axis_tlast  = l;
    bd.s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!bd.s_axis_tready && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!bd.s_axis_tready) begin
      failures++;
      $display("FAIL send_d_ready data=%h got tready=0 required 1 within 200 cycles", d);
    end
    @(posedge clk);
    #1;
    bd.s_axis_tvalid = 1'b0;
  endtask

  task automatic send_s(input logic [DW-1:0] d, input logic [SW-1:0] s,
                        input logic [TU-1:0] u, input logic l, output int w);
    w = 0;
    bs.s_axis_tdata  = d;
    bs.s_axis_tstrb  = s;
    bs.s_axis_tuser  = u;
    bs.s_axis_tlast  = l;
    bs.s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!bs.s_axis_tready && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!bs.s_axis_tready) begin
      failures++;
      $display("FAIL send_s_ready data=%h got tready=0 required 1 within 200 cycles", d);
    end
    @(posedge clk);
    #1;
    bs.s_axis_tvalid = 1'b0;
  endtask

  task automatic send_pkt_d(input int p, input int n);
    int w;
    for (int k = 0; k < n; k++) send_d(bdata(p, k), bstrb(k == n - 1), buser(p, k), (k == n - 1), w);
  endtask

  task automatic send_pkt_s(input int p, input int n);
    int w;
    for (int k = 0; k < n; k++) send_s(bdata(p, k), bstrb(k == n - 1), buser(p, k), (k == n - 1), w);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bd.m_axis_tvalid !== 2'b00) begin failures++; $display("FAIL rst_tvalid_d got=%b exp=00", bd.m_axis_tvalid); end
    checks++;
    if (bd.drop_pulse !== 2'b00) begin failures++; $display("FAIL rst_drop_d got=%b exp=00", bd.drop_pulse); end
    checks++;
    if (bd.s_axis_tready !== 1'b1) begin failures++; $display("FAIL rst_tready_d got=%b exp=1", bd.s_axis_tready); end
    checks++;
    if (bs.m_axis_tvalid !== 2'b00) begin failures++; $display("FAIL rst_tvalid_s got=%b exp=00", bs.m_axis_tvalid); end
    checks++;
    if (bs.s_axis_tready !== 1'b1) begin failures++; $display("FAIL rst_tready_s got=%b exp=1", bs.s_axis_tready); end
    rst_n = 1'b1;
    idle(2);
    checks++;
    if (bd.m_axis_tvalid !== 2'b00) begin failures++; $display("FAIL post_rst_tvalid got=%b exp=00", bd.m_axis_tvalid); end
  endtask

  task automatic test_baseline();
    int w;
    logic [EW-1:0] e;
    q0d.delete(); q1d.delete();
    bd.m_axis_tready = 2'b11;
    bd.out_enable    = 2'b11;
    checks++;
    if (bd.m_axis_tvalid !== 2'b00) begin failures++; $display("FAIL base_idle_tvalid got=%b exp=00", bd.m_axis_tvalid); end
    send_d(bdata(1, 0), 4'hF, 64'h1234_5678_01AB_CDEF, 1'b0, w);
    checks++;
    if (bd.m_axis_tvalid !== 2'b11) begin failures++; $display("FAIL base_latency_tvalid got=%b exp=11", bd.m_axis_tvalid); end
    checks++;
    if (bd.m_axis_tuser[31:24] !== 8'h80) begin failures++; $display("FAIL base_latency_dst0 got=%h exp=80", bd.m_axis_tuser[31:24]); end
    checks++;
    if (bd.m_axis_tuser[TU+24 +: 8] !== 8'h01) begin failures++; $display("FAIL base_latency_dst1 got=%h exp=01", bd.m_axis_tuser[TU+24 +: 8]); end
    for (int k = 1; k < 4; k++) send_d(bdata(1, k), bstrb(k == 3), buser(1, k), (k == 3), w);
    idle(5);
    checks++;
    if (q0d.size() != 4 || q1d.size() != 4) begin
      failures++; $display("FAIL base_count got=%0d/%0d exp=4/4", q0d.size(), q1d.size());
    end
    for (int k = 0; k < 4; k++) begin
      e = (k == 0) ? {1'b0, 64'h1234_5678_80AB_CDEF, 4'hF, bdata(1, 0)} : exp_entry(1, k, 4, 0);
      checks++;
      if (q0d[k] !== e) begin failures++; $display("FAIL base_out0_beat%0d got=%h exp=%h", k, q0d[k], e); end
      e = (k == 0) ? {1'b0, 64'h1234_5678_01AB_CDEF, 4'hF, bdata(1, 0)} : exp_entry(1, k, 4, 1);
      checks++;
      if (q1d[k] !== e) begin failures++; $display("FAIL base_out1_beat%0d got=%h exp=%h", k, q1d[k], e); end
    end
  endtask

  task automatic test_single_beat();
    int w;
    q0d.delete(); q1d.delete();
    for (int p = 2; p < 5; p++) begin
      send_d(bdata(p, 0), bstrb(1'b1), buser(p, 0), 1'b1, w);
      checks++;
      if (w != 0) begin failures++; $display("FAIL single_bubble p=%0d got waits=%0d exp=0", p, w); end
    end
    idle(5);
    checks++;
    if (q0d.size() != 3 || q1d.size() != 3) begin
      failures++; $display("FAIL single_count got=%0d/%0d exp=3/3", q0d.size(), q1d.size());
    end
    for (int p = 2; p < 5; p++) begin
      checks++;
      if (q0d[p-2] !== exp_entry(p, 0, 1, 0)) begin failures++; $display("FAIL single_out0_p%0d got=%h exp=%h", p, q0d[p-2], exp_entry(p, 0, 1, 0)); end
      checks++;
      if (q1d[p-2] !== exp_entry(p, 0, 1, 1)) begin failures++; $display("FAIL single_out1_p%0d got=%h exp=%h", p, q1d[p-2], exp_entry(p, 0, 1, 1)); end
    end
  endtask

  task automatic test_drop_mode();
    int w;
    q0d.delete(); q1d.delete();
    drop_seen_d = '0;
    bd.m_axis_tready = 2'b01;
    send_pkt_d(5, 6);
    send_pkt_d(6, 6);
    idle(3);
    // out1 now holds 12 beats, past its threshold of 10.
    send_d(bdata(7, 0), bstrb(1'b0), buser(7, 0), 1'b0, w);
    checks++;
    if (w != 0) begin failures++; $display("FAIL drop_tready_sop got waits=%0d exp=0", w); end
    checks++;
    if (bd.drop_pulse !== 2'b10) begin failures++; $display("FAIL drop_pulse_set got=%b exp=10", bd.drop_pulse); end
    send_d(bdata(7, 1), bstrb(1'b0), buser(7, 1), 1'b0, w);
    checks++;
    if (bd.drop_pulse !== 2'b00) begin failures++; $display("FAIL drop_pulse_clear got=%b exp=00", bd.drop_pulse); end
    send_d(bdata(7, 2), bstrb(1'b1), buser(7, 2), 1'b1, w);
    checks++;
    if (w != 0) begin failures++; $display("FAIL drop_tready_last got waits=%0d exp=0", w); end
    idle(5);
    checks++;
    if (q0d.size() != 15 || q1d.size() != 0) begin
      failures++; $display("FAIL drop_count got=%0d/%0d exp=15/0", q0d.size(), q1d.size());
    end
    checks++;
    if (drop_seen_d !== 2'b10) begin failures++; $display("FAIL drop_seen got=%b exp=10", drop_seen_d); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q0d[12+k] !== exp_entry(7, k, 3, 0)) begin failures++; $display("FAIL drop_out0_beat%0d got=%h exp=%h", k, q0d[12+k], exp_entry(7, k, 3, 0)); end
    end
    bd.m_axis_tready = 2'b11;
    idle(20);
    checks++;
    if (q1d.size() != 12) begin failures++; $display("FAIL drop_out1_count got=%0d exp=12", q1d.size()); end
    checks++;
    if (q1d[0] !== exp_entry(5, 0, 6, 1)) begin failures++; $display("FAIL drop_out1_first got=%h exp=%h", q1d[0], exp_entry(5, 0, 6, 1)); end
    checks++;
    if (q1d[11] !== exp_entry(6, 5, 6, 1)) begin failures++; $display("FAIL drop_out1_last got=%h exp=%h", q1d[11], exp_entry(6, 5, 6, 1)); end
  endtask

  task automatic test_stall_mode();
    int w;
    q0s.delete(); q1s.delete();
    drop_seen_s = '0;
    bs.out_enable    = 2'b11;
    bs.m_axis_tready = 2'b01;
    send_pkt_s(5, 6);
    send_pkt_s(6, 6);
    idle(3);
    bs.s_axis_tdata  = bdata(7, 0);
    bs.s_axis_tstrb  = bstrb(1'b0);
    bs.s_axis_tuser  = buser(7, 0);
    bs.s_axis_tlast  = 1'b0;
    bs.s_axis_tvalid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bs.s_axis_tready !== 1'b0) begin failures++; $display("FAIL stall_tready_c%0d got=%b exp=0", c, bs.s_axis_tready); end
    end
    @(posedge clk);
    #1;
    checks++;
    if (q0s.size() != 12) begin failures++; $display("FAIL stall_held_out0 got=%0d exp=12", q0s.size()); end
    bs.m_axis_tready = 2'b11;
    for (int k = 0; k < 3; k++) send_s(bdata(7, k), bstrb(k == 2), buser(7, k), (k == 2), w);
    idle(20);
    checks++;
    if (q0s.size() != 15 || q1s.size() != 15) begin
      failures++; $display("FAIL stall_count got=%0d/%0d exp=15/15", q0s.size(), q1s.size());
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q0s[12+k] !== exp_entry(7, k, 3, 0)) begin failures++; $display("FAIL stall_out0_beat%0d got=%h exp=%h", k, q0s[12+k], exp_entry(7, k, 3, 0)); end
      checks++;
      if (q1s[12+k] !== exp_entry(7, k, 3, 1)) begin failures++; $display("FAIL stall_out1_beat%0d got=%h exp=%h", k, q1s[12+k], exp_entry(7, k, 3, 1)); end
    end
    checks++;
    if (drop_seen_s !== 2'b00) begin failures++; $display("FAIL stall_drop got=%b exp=00", drop_seen_s); end
  endtask

  task automatic test_enable_mask();
    int w;
    q0d.delete(); q1d.delete();
    drop_seen_d = '0;
    bd.m_axis_tready = 2'b11;
    bd.out_enable    = 2'b11;
    send_d(bdata(8, 0), bstrb(1'b0), buser(8, 0), 1'b0, w);
    bd.out_enable = 2'b01;
    for (int k = 1; k < 4; k++) send_d(bdata(8, k), bstrb(k == 3), buser(8, k), (k == 3), w);
    send_pkt_d(9, 2);
    idle(5);
    checks++;
    if (q0d.size() != 6 || q1d.size() != 4) begin
      failures++; $display("FAIL en_count got=%0d/%0d exp=6/4", q0d.size(), q1d.size());
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (q1d[k] !== exp_entry(8, k, 4, 1)) begin failures++; $display("FAIL en_out1_beat%0d got=%h exp=%h", k, q1d[k], exp_entry(8, k, 4, 1)); end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (q0d[4+k] !== exp_entry(9, k, 2, 0)) begin failures++; $display("FAIL en_out0_p9_beat%0d got=%h exp=%h", k, q0d[4+k], exp_entry(9, k, 2, 0)); end
    end
    checks++;
    if (drop_seen_d !== 2'b00) begin failures++; $display("FAIL en_drop got=%b exp=00", drop_seen_d); end
    bd.out_enable = 2'b11;
  endtask

  task automatic test_reset_mid();
    int w;
    q0d.delete(); q1d.delete();
    bd.m_axis_tready = 2'b00;
    send_d(bdata(10, 0), bstrb(1'b0), buser(10, 0), 1'b0, w);
    send_d(bdata(10, 1), bstrb(1'b0), buser(10, 1), 1'b0, w);
    bd.s_axis_tdata  = bdata(10, 2);
    bd.s_axis_tstrb  = bstrb(1'b0);
    bd.s_axis_tuser  = buser(10, 2);
    bd.s_axis_tlast  = 1'b0;
    bd.s_axis_tvalid = 1'b1;
    @(negedge clk);
    checks++;
    if (bd.m_axis_tvalid !== 2'b11) begin failures++; $display("FAIL rmid_pre_tvalid got=%b exp=11", bd.m_axis_tvalid); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bd.m_axis_tvalid !== 2'b00) begin failures++; $display("FAIL rmid_async_tvalid got=%b exp=00", bd.m_axis_tvalid); end
    bd.s_axis_tvalid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    checks++;
    if (bd.m_axis_tvalid !== 2'b00) begin failures++; $display("FAIL rmid_post_tvalid got=%b exp=00", bd.m_axis_tvalid); end
    bd.m_axis_tready = 2'b11;
    send_pkt_d(11, 3);
    idle(5);
    checks++;
    if (q0d.size() != 3 || q1d.size() != 3) begin
      failures++; $display("FAIL rmid_count got=%0d/%0d exp=3/3", q0d.size(), q1d.size());
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (q0d[k] !== exp_entry(11, k, 3, 0)) begin failures++; $display("FAIL rmid_out0_beat%0d got=%h exp=%h", k, q0d[k], exp_entry(11, k, 3, 0)); end
      checks++;
      if (q1d[k] !== exp_entry(11, k, 3, 1)) begin failures++; $display("FAIL rmid_out1_beat%0d got=%h exp=%h", k, q1d[k], exp_entry(11, k, 3, 1)); end
    end
  endtask

  initial begin
    bd.s_axis_tdata  = '0; bd.s_axis_tstrb = '0; bd.s_axis_tuser = '0;
    bd.s_axis_tlast  = 1'b0; bd.s_axis_tvalid = 1'b0;
    bd.m_axis_tready = 2'b11; bd.out_enable = 2'b11;
    bs.s_axis_tdata  = '0; bs.s_axis_tstrb = '0; bs.s_axis_tuser = '0;
    bs.s_axis_tlast  = 1'b0; bs.s_axis_tvalid = 1'b0;
    bs.m_axis_tready = 2'b11; bs.out_enable = 2'b11;

    test_reset();
    test_baseline();
    test_single_beat();
    test_drop_mode();
    test_stall_mode();
    test_enable_mask();
    test_reset_mid();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_replicator.md
Name: packet_replicator

Overview:
- Parametrised successor to the two-port packet duplicator in the packet_capture datapath.
- Accepts one AXI4-Stream input and replicates each packet to NUM_OUTPUTS independently back-pressured outputs.
- Each output copy gets its own destination-port code written into the TUSER dst field on the first beat.
- Per-output enable mask and an optional drop-on-full mode, so a slow capture/host port cannot stall the line-rate port.

Parameters:
- C_AXIS_DATA_WIDTH, 256, TDATA width; TSTRB is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128, TUSER width.
- NUM_OUTPUTS, 2, number of output streams (1..8).
- FIFO_DEPTH_BITS, 7, log2 of per-output FIFO depth in beats.
- MAX_PKT_WORDS, 50, beats reserved per packet at SOP (1600 B at 32 B/beat); must be < 2**FIFO_DEPTH_BITS.
- DST_PORT_LSB, 24, LSB of the TUSER dst-port field.
- DST_PORT_WIDTH, 8, width of the dst-port field.
- OUT_DST_PORTS, {8'h80,8'h01}, packed NUM_OUTPUTS*DST_PORT_WIDTH; slice i is written into output i's dst field.
- DROP_ON_FULL, 1, 1 = drop the copy for an output lacking room; 0 = stall the input.

Ports:
- axi_aclk  in  1  clock.
- axi_aresetn  in  1  asynchronous active-low reset.
- s_axis_tdata  in  C_AXIS_DATA_WIDTH  input data.
- s_axis_tstrb  in  C_AXIS_DATA_WIDTH/8  byte strobes.
- s_axis_tuser  in  C_AXIS_TUSER_WIDTH  metadata; valid on the first beat.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- s_axis_tlast  in  1  end of packet.
- m_axis_tdata  out  NUM_OUTPUTS*C_AXIS_DATA_WIDTH  packed; slice i is output i.
- m_axis_tstrb  out  NUM_OUTPUTS*C_AXIS_DATA_WIDTH/8  packed.
- m_axis_tuser  out  NUM_OUTPUTS*C_AXIS_TUSER_WIDTH  packed.
- m_axis_tvalid  out  NUM_OUTPUTS  per-output valid.
- m_axis_tready  in  NUM_OUTPUTS  per-output ready.
- m_axis_tlast  out  NUM_OUTPUTS  per-output last.
- out_enable  in  NUM_OUTPUTS  per-output enable; sampled only on the SOP beat.
- drop_pulse  out  NUM_OUTPUTS  1-cycle pulse per output whose copy was dropped.

Behaviour:
- Reset: asynchronous; clears state to SOP, sel_mask to 0, drop_pulse to 0, and resets all FIFOs (m_axis_tvalid=0). Reset mid-packet discards partial packets in flight and in the FIFOs; no recovery of partial packets.
- Input handshake: a beat is accepted when s_axis_tvalid & s_axis_tready. Inputs are never buffered outside the FIFOs.
- room[i] = !prog_full[i], where the prog_full threshold is 2**FIFO_DEPTH_BITS - MAX_PKT_WORDS.
- State SOP (awaiting first beat):
  - want = out_enable.
  - DROP_ON_FULL=1: s_axis_tready=1. On accept, sel_mask = want & room and drop_pulse = want & ~room (registered, asserted the next cycle).
  - DROP_ON_FULL=0: s_axis_tready = &(room | ~want). On accept, sel_mask = want and drop_pulse stays 0.
  - Transitions: accept with tlast=0 -> IN_PKT; accept with tlast=1 (single-beat packet) -> stays in SOP.
- State IN_PKT: s_axis_tready = &(~full | ~sel_mask); accepts with tlast=1 -> SOP.
- Write enable for FIFO i = accept & mask_i, where mask is the combinational SOP mask on the first beat and the registered sel_mask afterwards.
- A zero mask (all outputs disabled or dropped) consumes and discards the packet.
- TUSER rewrite: on the first beat only, FIFO i receives s_axis_tuser with bits [DST_PORT_LSB +: DST_PORT_WIDTH] replaced by OUT_DST_PORTS slice i. All other bits and later beats pass unchanged. TDATA, TSTRB and TLAST always pass unchanged.
- Outputs: fallthrough FIFOs.
  - m_axis_tvalid[i] = !empty[i]; read when tvalid[i] & tready[i].
  - Latency: a beat accepted at cycle N is visible on the outputs at cycle N+1.
  - Outputs drain fully independently; a stalled output never blocks the others except through its own FIFO's room check.
- Oversize packets (> MAX_PKT_WORDS beats): never dropped mid-packet. The input stalls while a selected FIFO is full, and packet integrity holds.
- Ordering: each output preserves input packet order; beats of different packets never interleave.

Decomposition:
- Shared include packet_capture_defs.vh holds TUSER field offsets (DST_PORT_LSB, SRC_PORT_LSB, widths) and the standard port codes (host 8'h80, MAC ports).
- One natural sub-module: per-output queue, using the existing fallthrough_small_fifo with prog_full. It is instantiated NUM_OUTPUTS times in a generate loop.
- The control FSM, mask logic and TUSER rewrite stay in the top level.

Test Plan:
- Baseline copy: NUM_OUTPUTS=2, out_enable=2'b11, all tready=1, one 4-beat packet with tuser[31:24]=8'h01 -> both outputs carry identical data/tstrb/tlast, first-beat dst=8'h80 on out0 and 8'h01 on out1, first beat visible one cycle after acceptance.
- Single-beat packets: 3 back-to-back packets with tlast on every beat -> 3 packets per output, FSM never leaves SOP, no bubbles on the input.
- Drop mode: out1 tready=0 until its FIFO is past prog_full, then send a packet -> drop_pulse=2'b10 for one cycle, out0 receives the packet, out1 receives nothing extra, s_axis_tready stays 1.
- Stall mode: DROP_ON_FULL=0, same setup -> s_axis_tready=0 at SOP until out1 drains below threshold, then both outputs receive the packet intact.
- Enable mask: out_enable changes from 2'b11 to 2'b01 mid-packet -> the current packet still goes to both outputs; the next packet goes to out0 only; drop_pulse stays 0.
- Reset mid-packet: assert axi_aresetn=0 during beat 2 of a 5-beat packet -> all m_axis_tvalid=0 immediately, FSM in SOP; the next full packet is delivered correctly to both outputs.
